// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch controller.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUNNING = 2'd1,
        ST_PAUSED  = 2'd2,
        ST_LAP     = 2'd3
    } sw_state_e;

    // Digit limits of the M:SS display
    localparam logic [3:0] SEC_ONES_MAX = 4'd9;
    localparam logic [3:0] SEC_TENS_MAX = 4'd5;
    localparam logic [3:0] MIN_ONES_MAX = 4'd9;

    typedef struct packed {
        logic [3:0] min_ones;
        logic [3:0] sec_tens;
        logic [3:0] sec_ones;
    } sw_time_t;

    // Advance a BCD M:SS time by one second; 9:59 wraps to 0:00
    function automatic sw_time_t time_inc(input sw_time_t t);
        sw_time_t r;
        r = t;
        if (t.sec_ones == SEC_ONES_MAX) begin
            r.sec_ones = 4'd0;
            if (t.sec_tens == SEC_TENS_MAX) begin
                r.sec_tens = 4'd0;
                if (t.min_ones == MIN_ONES_MAX) r.min_ones = 4'd0;
                else                            r.min_ones = t.min_ones + 4'd1;
            end else begin
                r.sec_tens = t.sec_tens + 4'd1;
            end
        end else begin
            r.sec_ones = t.sec_ones + 4'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/stopwatch_tick.sv
// One-second prescaler: counts 0..TICK_DIV-1 while enabled and flags the wrap.
module stopwatch_tick #(
    parameter int unsigned TICK_DIV = 1000000
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic tick
);
    localparam int unsigned CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // tick is combinational so the owner can apply it on the very wrap edge
    assign tick = enable && (cnt_q == LAST);

    // Next count: clear wins, otherwise count only when enabled
    always_comb begin
        cnt_d = cnt_q;
        if (clear)       cnt_d = '0;
        else if (tick)   cnt_d = '0;
        else if (enable) cnt_d = cnt_q + CW'(1);
    end

    // Counter register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: start/pause/lap FSM, BCD live time and lap snapshot.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned TICK_DIV = 1000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       btn_start,
    input  logic       btn_clear,
    input  logic       btn_lap,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic       running,
    output logic       lap_active,
    output logic       tick
);
    sw_state_e state_q, state_d;
    sw_time_t  live_q, live_d, snap_q, snap_d, disp_q, disp_d;
    logic      running_q, running_d, lap_q, lap_d, tick_q, tick_d;
    logic      cnt_en, clr_acc, lap_acc, pre_tick;

    // Counting follows the registered state, so a pause/lap pulse never drops a tick
    assign cnt_en = (state_q == ST_RUNNING) || (state_q == ST_LAP);

    stopwatch_tick #(.TICK_DIV(TICK_DIV)) u_tick (
        .clock  (clock),
        .reset  (reset),
        .enable (cnt_en),
        .clear  (clr_acc),
        .tick   (pre_tick)
    );

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next state; buttons not legal in a state are dropped before priority applies
    always_comb begin
        state_d = state_q;
        clr_acc = 1'b0;
        lap_acc = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (btn_clear)      clr_acc = 1'b1;
                else if (btn_start) state_d = ST_RUNNING;
            end
            ST_RUNNING: begin
                if (btn_start) state_d = ST_PAUSED;
                else if (btn_lap) begin
                    state_d = ST_LAP;
                    lap_acc = 1'b1;
                end
            end
            ST_PAUSED: begin
                if (btn_clear) begin
                    state_d = ST_IDLE;
                    clr_acc = 1'b1;
                end else if (btn_start) begin
                    state_d = ST_RUNNING;
                end
            end
            ST_LAP: begin
                if (btn_start)    state_d = ST_PAUSED;
                else if (btn_lap) state_d = ST_RUNNING;
            end
        endcase
    end

    // Next time, snapshot and output values; outputs are built from next state
    // so the registered display changes on the same edge as the live time
    always_comb begin
        live_d = live_q;
        if (clr_acc)       live_d = '0;
        else if (pre_tick) live_d = time_inc(live_q);
        snap_d = snap_q;
        if (clr_acc)       snap_d = '0;
        else if (lap_acc)  snap_d = live_q;
        running_d = (state_d == ST_RUNNING) || (state_d == ST_LAP);
        lap_d     = (state_d == ST_LAP);
        disp_d    = lap_d ? snap_d : live_d;
        tick_d    = pre_tick;
    end

    // Time and output registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            live_q    <= '0;
            snap_q    <= '0;
            disp_q    <= '0;
            running_q <= 1'b0;
            lap_q     <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            live_q    <= live_d;
            snap_q    <= snap_d;
            disp_q    <= disp_d;
            running_q <= running_d;
            lap_q     <= lap_d;
            tick_q    <= tick_d;
        end
    end

    assign sec_ones   = disp_q.sec_ones;
    assign sec_tens   = disp_q.sec_tens;
    assign min_ones   = disp_q.min_ones;
    assign running    = running_q;
    assign lap_active = lap_q;
    assign tick       = tick_q;

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 1000000, SHALL set the clock cycles per one-second tick; legal range is 2 to 2^20.
REQ-002 Port clock, input, 1 bit, SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port reset, input, 1 bit, SHALL be the asynchronous, active-low reset.
REQ-004 Port btn_start, input, 1 bit, SHALL be a one-cycle start/pause pulse that has already been debounced.
REQ-005 Port btn_clear, input, 1 bit, SHALL be a one-cycle clear pulse.
REQ-006 Port btn_lap, input, 1 bit, SHALL be a one-cycle lap-freeze/release pulse.
REQ-007 Port sec_ones, output, 4 bits, SHALL carry the displayed seconds units in BCD, 0-9.
REQ-008 Port sec_tens, output, 4 bits, SHALL carry the displayed seconds tens in BCD, 0-5.
REQ-009 Port min_ones, output, 4 bits, SHALL carry the displayed minutes in BCD, 0-9.
REQ-010 Port running, output, 1 bit, SHALL be high in RUNNING and LAP.
REQ-011 Port lap_active, output, 1 bit, SHALL be high in LAP only.
REQ-012 Port tick, output, 1 bit, SHALL pulse for one cycle on each one-second advance.

Function
REQ-013 FSM states SHALL be IDLE, RUNNING, PAUSED and LAP.
REQ-014 Transitions SHALL be:
- IDLE -start-> RUNNING
- RUNNING -start-> PAUSED
- RUNNING -lap-> LAP
- PAUSED -start-> RUNNING
- PAUSED -clear-> IDLE
- LAP -lap-> RUNNING
- LAP -start-> PAUSED
- Every other button/state pair is ignored.
REQ-015 Button priority in a single cycle SHALL be clear > start > lap; ignored buttons have no effect.
REQ-016 Clear in IDLE SHALL re-zero the time and the prescaler and stay in IDLE.
REQ-017 Clear in RUNNING or LAP SHALL be ignored.
REQ-018 The prescaler SHALL count 0..TICK_DIV-1 only while the registered state is RUNNING or LAP; otherwise it holds its value.
REQ-019 When prescaler == TICK_DIV-1 with counting enabled, the prescaler SHALL return to 0 and tick SHALL assert in that same cycle.
REQ-020 Pause SHALL retain the prescaler value; a resume continues from it and does not restart the second.
REQ-021 The live time SHALL advance by one second on each tick, with BCD carries sec_ones 9->0, sec_tens 5->0 and min_ones +1.
REQ-022 The time 9:59 plus one tick SHALL wrap to 0:00 with no overflow flag.
REQ-023 A tick coinciding with a start (pause) or lap pulse SHALL still be applied, because counting enable uses the current registered state.
REQ-024 Display outputs SHALL show the live time, except in LAP.
REQ-025 In LAP the display SHALL show a snapshot of the live time registered in the cycle the lap pulse is accepted; the live time keeps counting.
REQ-026 On leaving LAP by either lap or start, the display SHALL show the live time from the next cycle.
REQ-027 All outputs SHALL be registered; a time change appears on the outputs the cycle after tick.
REQ-028 Clear accepted in PAUSED SHALL zero the live time, the snapshot and the prescaler in the next cycle.

Reset
REQ-029 Asserting reset (low) SHALL immediately force the following values:
- state IDLE
- prescaler 0
- live time 0:00 and snapshot 0:00
- all outputs 0
REQ-030 Reset asserted mid-operation, including in LAP, SHALL discard all time state.
REQ-031 Button pulses coincident with reset deassertion SHALL be ignored in that cycle.

Structure
REQ-032 The FSM state encodings and the BCD limit constants (9, 5) SHALL reside in a shared package/header, stopwatch_pkg.
REQ-033 The prescaler SHALL be a sub-module, stopwatch_tick, with ports clock, reset, enable, clear and tick.
REQ-034 stopwatch_tick's counter SHALL be sized to ceil(log2(TICK_DIV)) bits.
REQ-035 The FSM, the BCD counter and the snapshot register SHALL reside in stopwatch_ctrl.

Verification (TICK_DIV=4)
REQ-036 Reset, then start, then 12 cycles -> tick pulses exactly 3 times, 4 cycles apart; display reads 0:03.
REQ-037 Run to 0:58 (sec_tens=5, sec_ones=8), then 2 ticks -> display reads 0:59, then 1:00.
REQ-038 Preload via run to 9:59, then 1 tick -> display reads 0:00 and running stays 1.
REQ-039 Run 2 cycles into a second, pause for 10 cycles, resume -> next tick arrives 2 cycles after resume, with no tick while PAUSED.
REQ-040 At 0:05 press lap, run 8 cycles -> display holds 0:05 and lap_active=1; press lap again -> display reads 0:07.
REQ-041 Cases for clear and reset:
- Clear while RUNNING -> ignored.
- Start and clear in the same cycle while PAUSED -> IDLE with 0:00.
- Reset pulled low mid-LAP -> all outputs 0 without waiting for a clock edge.
